// File: rtl/fft16.sv
// fft16: 16-point radix-2 DIT FFT on Q15 complex frames, 1/16 scaled. Latency: 5 enabled clocks.
// No backpressure: one frame per enabled cycle; enable low freezes every pipeline register.
module fft16 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] zr [0:15],
    input  logic signed [DATA_WIDTH-1:0] zi [0:15],
    output logic signed [DATA_WIDTH-1:0] Zr [0:15],
    output logic signed [DATA_WIDTH-1:0] Zi [0:15]
);
    localparam int N  = 16;
    localparam int W  = DATA_WIDTH;
    localparam int TW = W + 2;
    localparam int PW = 2 * W + 1;

    localparam logic signed [TW-1:0] SMAX = {3'b000, {(W - 1){1'b1}}};
    localparam logic signed [TW-1:0] SMIN = ~SMAX;
    localparam logic signed [W-1:0]  DMAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0]  DMIN = {1'b1, {(W - 1){1'b0}}};

    typedef struct packed {
        logic signed [W-1:0] ur;
        logic signed [W-1:0] ui;
        logic signed [W-1:0] lr;
        logic signed [W-1:0] li;
    } bfly_t;

    logic signed [W-1:0] sr [0:4][0:N-1];
    logic signed [W-1:0] si [0:4][0:N-1];
    logic signed [W-1:0] nr [1:4][0:N-1];
    logic signed [W-1:0] ni [1:4][0:N-1];
    bfly_t               bo;

    function automatic logic [3:0] bitrev(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [TW-1:0] x);
        if (x > SMAX) return DMAX;
        if (x < SMIN) return DMIN;
        return x[W-1:0];
    endfunction

    // W^m = cos - j*sin for m = 0..7, Q15; m = 0 and m = 4 never reach the multiplier.
    function automatic bfly_t bfly(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                                   input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                                   input logic [2:0] m);
        logic signed [15:0]   wr;
        logic signed [15:0]   wi;
        logic signed [PW-1:0] pr;
        logic signed [PW-1:0] pq;
        logic signed [TW-1:0] tr;
        logic signed [TW-1:0] ti;
        bfly_t                o;
        case (m)
            3'd1:    begin wr =  16'sd30274; wi = -16'sd12540; end
            3'd2:    begin wr =  16'sd23170; wi = -16'sd23170; end
            3'd3:    begin wr =  16'sd12540; wi = -16'sd30274; end
            3'd5:    begin wr = -16'sd12540; wi = -16'sd30274; end
            3'd6:    begin wr = -16'sd23170; wi = -16'sd23170; end
            3'd7:    begin wr = -16'sd30274; wi = -16'sd12540; end
            default: begin wr =  16'sd32767; wi =  16'sd0;     end
        endcase
        pr = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
        pq = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
        case (m)
            3'd0: begin
                tr = TW'(br);
                ti = TW'(bi);
            end
            3'd4: begin
                tr = TW'(bi);
                ti = (br == DMIN) ? TW'(DMAX) : -TW'(br);
            end
            default: begin
                tr = TW'(pr >>> 15);
                ti = TW'(pq >>> 15);
            end
        endcase
        o.ur = sat((TW'(ar) + tr) >>> 1);
        o.ui = sat((TW'(ai) + ti) >>> 1);
        o.lr = sat((TW'(ar) - tr) >>> 1);
        o.li = sat((TW'(ai) - ti) >>> 1);
        return o;
    endfunction

    // Stage s pairs g with g + 2^(s-1); twiddle index is the offset within the group times 16/2^s.
    always_comb begin
        bo = '0;
        for (int s = 1; s <= 4; s++) begin
            for (int g = 0; g < N; g++) begin
                nr[s][g] = '0;
                ni[s][g] = '0;
            end
        end
        for (int s = 1; s <= 4; s++) begin
            for (int g = 0; g < N; g++) begin
                if (((g >> (s - 1)) & 1) == 0) begin
                    bo = bfly(sr[s-1][g], si[s-1][g],
                              sr[s-1][g + (1 << (s - 1))], si[s-1][g + (1 << (s - 1))],
                              3'((g & ((1 << (s - 1)) - 1)) * (N >> s)));
                    nr[s][g] = bo.ur;
                    ni[s][g] = bo.ui;
                    nr[s][g + (1 << (s - 1))] = bo.lr;
                    ni[s][g + (1 << (s - 1))] = bo.li;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= 4; s++) begin
                for (int k = 0; k < N; k++) begin
                    sr[s][k] <= '0;
                    si[s][k] <= '0;
                end
            end
        end else if (enable) begin
            for (int k = 0; k < N; k++) begin
                sr[0][k] <= zr[bitrev(4'(k))];
                si[0][k] <= zi[bitrev(4'(k))];
            end
            for (int s = 1; s <= 4; s++) begin
                for (int k = 0; k < N; k++) begin
                    sr[s][k] <= nr[s][k];
                    si[s][k] <= ni[s][k];
                end
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign Zr[k] = sr[4][k];
        assign Zi[k] = si[4][k];
    end

endmodule

// File: tb/tb_fft16.sv
// Self-checking bench for fft16: arithmetic reference FFT plus a 5-deep frame queue for pipeline timing.
module tb_fft16;
    logic               clk;
    logic               rst_n;
    logic               enable;
    logic signed [15:0] zr [0:15];
    logic signed [15:0] zi [0:15];
    logic signed [15:0] Zr [0:15];
    logic signed [15:0] Zi [0:15];

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [511:0] pipe [$];
    logic [511:0] got;
    logic [511:0] want;
    logic [511:0] held_a;
    logic [511:0] held_b;

    fft16 #(.DATA_WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .zr     (zr),
        .zi     (zi),
        .Zr     (Zr),
        .Zi     (Zi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat16(input int x);
        return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Bin k packed at bits [k*32 +: 32] as {re, im}.
    function automatic logic [511:0] ref_fft();
        int ar [16];
        int ai [16];
        int h, m, u, l, r, tr, ti, wr, wi, xr, xi;
        longint pr, pq;
        real ang;
        logic [511:0] v;
        for (int n = 0; n < 16; n++) begin
            r = 0;
            for (int b = 0; b < 4; b++) r = r * 2 + ((n >> b) & 1);
            ar[n] = zr[r];
            ai[n] = zi[r];
        end
        for (int s = 1; s <= 4; s++) begin
            h = 1 << (s - 1);
            for (int g = 0; g < 16; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    m = j * (16 >> s);
                    u = g + j;
                    l = u + h;
                    if (m == 0) begin
                        tr = ar[l];
                        ti = ai[l];
                    end else if (m == 4) begin
                        tr = ai[l];
                        ti = sat16(-ar[l]);
                    end else begin
                        ang = 2.0 * 3.14159265358979 * m / 16.0;
                        wr  = sat16(rnd(32768.0 * $cos(ang)));
                        wi  = sat16(rnd(-32768.0 * $sin(ang)));
                        pr  = longint'(ar[l]) * wr - longint'(ai[l]) * wi;
                        pq  = longint'(ar[l]) * wi + longint'(ai[l]) * wr;
                        tr  = int'(pr >>> 15);
                        ti  = int'(pq >>> 15);
                    end
                    xr = ar[u];
                    xi = ai[u];
                    ar[u] = sat16((xr + tr) >>> 1);
                    ai[u] = sat16((xi + ti) >>> 1);
                    ar[l] = sat16((xr - tr) >>> 1);
                    ai[l] = sat16((xi - ti) >>> 1);
                end
            end
        end
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = {16'(ar[k]), 16'(ai[k])};
        return v;
    endfunction

    function automatic logic [511:0] dut_vec();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = {Zr[k], Zi[k]};
        return v;
    endfunction

    task automatic clear_pipe();
        pipe = {};
        for (int i = 0; i < 5; i++) pipe.push_back('0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && enable) begin
            pipe.push_front(ref_fft());
            void'(pipe.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic rand_frame(input bit extremes);
        for (int k = 0; k < 16; k++) begin
            if (extremes) begin
                zr[k] = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
                zi[k] = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
            end else begin
                zr[k] = 16'($urandom);
                zi[k] = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        enable = 1'b1;
        rand_frame(1'b0);
        #1 rst_n = 1'b0;
        clear_pipe();
        #1;
        got = dut_vec();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", got);
        end
        for (int c = 0; c < 3; c++) begin
            rand_frame(1'b0);
            tick();
            got = dut_vec();
            n_checks++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected 0", got);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            zr[k] = 16'sh7FFF;
            zi[k] = 16'sh7FFF;
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            got = dut_vec();
            n_checks++;
            if (got !== pipe[4]) begin
                n_fail++;
                $display("FAIL dc_stream: got %h expected %h", got, pipe[4]);
            end
        end
        want = '0;
        want[31:0] = {16'sh7FFF, 16'sh7FFF};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL dc_bins: got %h expected %h", got, want);
        end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < 16; k++) begin
            zr[k] = 16'sd0;
            zi[k] = 16'sd0;
        end
        zr[0] = 16'sd32767;
        for (int c = 0; c < 5; c++) tick();
        got = dut_vec();
        for (int k = 0; k < 16; k++) want[k*32 +: 32] = {16'sd2047, 16'sd0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL impulse: got %h expected %h", got, want);
        end
        n_checks++;
        if (got !== pipe[4]) begin
            n_fail++;
            $display("FAIL impulse_model: got %h expected %h", got, pipe[4]);
        end
    endtask

    task automatic test_alternating();
        for (int k = 0; k < 16; k++) begin
            zr[k] = (k % 2 == 1) ? -16'sd16384 : 16'sd16384;
            zi[k] = 16'sd0;
        end
        for (int c = 0; c < 5; c++) tick();
        got  = dut_vec();
        want = '0;
        want[8*32 +: 32] = {16'sd16384, 16'sd0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL alternating: got %h expected %h", got, want);
        end
        n_checks++;
        if (got !== pipe[4]) begin
            n_fail++;
            $display("FAIL alternating_model: got %h expected %h", got, pipe[4]);
        end
    endtask

    task automatic test_full_scale();
        for (int k = 0; k < 16; k++) begin
            zr[k] = 16'sh8000;
            zi[k] = 16'sh8000;
        end
        for (int c = 0; c < 5; c++) tick();
        got  = dut_vec();
        want = '0;
        want[31:0] = {16'sh8000, 16'sh8000};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL full_scale_neg: got %h expected %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 16; f++) begin
            rand_frame(f % 2 == 1);
            tick();
            got = dut_vec();
            n_checks++;
            if (got !== pipe[4]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", f, got, pipe[4]);
            end
        end
    endtask

    task automatic test_latency();
        rand_frame(1'b0);
        held_a = ref_fft();
        for (int c = 0; c < 5; c++) tick();
        rand_frame(1'b1);
        held_b = ref_fft();
        for (int c = 1; c <= 5; c++) begin
            tick();
            got  = dut_vec();
            want = (c < 5) ? held_a : held_b;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL latency_edge%0d: got %h expected %h", c, got, want);
            end
        end
    endtask

    task automatic test_enable_hold();
        for (int c = 0; c < 4; c++) begin
            rand_frame(1'b0);
            tick();
        end
        held_a = pipe[4];
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_frame(1'b1);
            tick();
            got = dut_vec();
            n_checks++;
            if (got !== held_a) begin
                n_fail++;
                $display("FAIL enable_hold%0d: got %h expected %h", c, got, held_a);
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_frame(1'b0);
            tick();
            got = dut_vec();
            n_checks++;
            if (got !== pipe[4]) begin
                n_fail++;
                $display("FAIL enable_resume%0d: got %h expected %h", c, got, pipe[4]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin
            rand_frame(1'b0);
            tick();
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        clear_pipe();
        #1;
        got = dut_vec();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL midstream_reset: got %h expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_frame(1'b0);
        zr[0] = 16'sd12000;
        zr[1] = 16'sd9000;
        held_b = ref_fft();
        for (int c = 1; c <= 5; c++) begin
            tick();
            got  = dut_vec();
            want = (c < 5) ? 512'd0 : held_b;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL post_reset_edge%0d: got %h expected %h", c, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_alternating();
        test_full_scale();
        test_back_to_back();
        test_latency();
        test_enable_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
